// File: rtl/rcservo_sequencer.sv
// Multi-channel RC servo pulse sequencer.
// One shared microsecond tick drives a repeating frame split into per-channel slots;
// each channel pulses at the start of its own slot, so at most one output is high at a time.
// Optional feature: define RCSERVO_SLEW_EN to rate-limit width changes per frame.
module rcservo_sequencer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned TICK_DIV  = 50,
  parameter int unsigned FRAME_US  = 20000,
  parameter int unsigned SLOT_US   = 2500,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned CENTER_US = 1500,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned SLEW_US   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [CHANNELS-1:0]    channel_en,
  input  logic [CHANNELS*16-1:0] position,
  input  logic                   load,
  output logic [CHANNELS-1:0]    pwm,
  output logic                   frame_start,
  output logic                   busy
);

  if (!(CHANNELS >= 1 && CHANNELS <= 16 && TICK_DIV >= 1 && TICK_DIV <= 65536 &&
        MIN_US <= CENTER_US && CENTER_US <= MAX_US && MAX_US < SLOT_US &&
        CHANNELS * SLOT_US <= FRAME_US && FRAME_US <= 65536 && SLEW_US < 65536))
  begin : g_bad_params
    $error("rcservo_sequencer: illegal parameter combination");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  localparam logic [15:0] TickLast  = 16'(TICK_DIV - 1);
  localparam logic [15:0] FrameLast = 16'(FRAME_US - 1);
  localparam logic [15:0] SlotLast  = 16'(SLOT_US - 1);
  localparam logic [15:0] Center16  = 16'(CENTER_US);
  localparam logic [15:0] Min16     = 16'(MIN_US);
  localparam logic [15:0] Max16     = 16'(MAX_US);
  localparam logic signed [17:0] MinS = 18'(MIN_US);
  localparam logic signed [17:0] MaxS = 18'(MAX_US);

  logic [1:0]          state_q, state_d;
  logic [15:0]         presc_q, presc_d;
  logic [15:0]         tick_q, tick_d;
  logic [15:0]         slot_tick_q, slot_tick_d;
  logic [15:0]         slot_idx_q, slot_idx_d;
  logic                stop_q, stop_d;
  logic                cur_en_q, cur_en_d;
  logic                slot_begin;
  logic [15:0]         shadow_q [CHANNELS];
  logic [15:0]         shadow_d [CHANNELS];
  logic [15:0]         active_q [CHANNELS];
  logic [15:0]         active_d [CHANNELS];
  logic [15:0]         target   [CHANNELS];
  logic signed [17:0]  sum;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                fs_q, fs_d;
  logic                busy_q, busy_d;

  // Clamp centre+offset per channel and stage it into the shadow registers on load.
  always_comb begin
    sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum = $signed({2'b00, Center16}) +
            $signed({{2{position[16*k+15]}}, position[16*k +: 16]});
      if (sum < MinS)      target[k] = Min16;
      else if (sum > MaxS) target[k] = Max16;
      else                 target[k] = sum[15:0];
      shadow_d[k] = load ? target[k] : shadow_q[k];
    end
  end

  // Active widths change only in START; they hold across RUN and IDLE.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      active_d[k] = active_q[k];
      if (state_q == StStart) begin
`ifdef RCSERVO_SLEW_EN
        if ({1'b0, shadow_q[k]} > {1'b0, active_q[k]} + 17'(SLEW_US)) begin
          active_d[k] = active_q[k] + 16'(SLEW_US);
        end else if ({1'b0, shadow_q[k]} + 17'(SLEW_US) < {1'b0, active_q[k]}) begin
          active_d[k] = active_q[k] - 16'(SLEW_US);
        end else begin
          active_d[k] = shadow_q[k];
        end
`else
        active_d[k] = shadow_q[k];
`endif
      end
    end
  end

  // Frame sequencer: prescaler, frame tick, slot position and the stop request.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    slot_tick_d = slot_tick_q;
    slot_idx_d  = slot_idx_q;
    stop_d      = stop_q;
    cur_en_d    = cur_en_q;
    slot_begin  = 1'b0;
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (enable) state_d = StStart;
      end
      StStart: begin
        state_d     = StRun;
        presc_d     = '0;
        tick_d      = '0;
        slot_tick_d = '0;
        slot_idx_d  = '0;
        stop_d      = ~enable;
        slot_begin  = 1'b1;
      end
      StRun: begin
        // Once enable is seen low the frame winds down at the end of the current slot.
        stop_d = stop_q | ~enable;
        if (presc_q == TickLast) begin
          presc_d = '0;
          if (tick_q == FrameLast) begin
            state_d = stop_d ? StIdle : StStart;
          end else if (stop_d && slot_tick_q == SlotLast) begin
            state_d = StIdle;
          end else begin
            tick_d = tick_q + 16'd1;
            if (slot_tick_q == SlotLast) begin
              slot_tick_d = '0;
              slot_idx_d  = slot_idx_q + 16'd1;
              slot_begin  = 1'b1;
            end else begin
              slot_tick_d = slot_tick_q + 16'd1;
            end
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // channel_en is captured only at the slot start so a mid-pulse change cannot cut it.
    if (slot_begin) begin
      cur_en_d = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (slot_idx_d == 16'(k)) cur_en_d = channel_en[k] & ~stop_d;
      end
    end
  end

  // Registered outputs computed from the next-state view of the sequencer.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      pwm_d[k] = (state_d == StRun) && cur_en_d && (slot_idx_d == 16'(k)) &&
                 (slot_tick_d < active_d[k]);
    end
    fs_d   = (state_d == StStart);
    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      tick_q      <= '0;
      slot_tick_q <= '0;
      slot_idx_q  <= '0;
      stop_q      <= 1'b0;
      cur_en_q    <= 1'b0;
      pwm_q       <= '0;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= Center16;
        active_q[k] <= Center16;
      end
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      slot_tick_q <= slot_tick_d;
      slot_idx_q  <= slot_idx_d;
      stop_q      <= stop_d;
      cur_en_q    <= cur_en_d;
      pwm_q       <= pwm_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rcservo_sequencer.sv
// Bench for rcservo_sequencer: directed scenarios plus random loads/enables,
// every cycle compared against a frame-arithmetic reference model.
module tb_rcservo_sequencer;

  localparam int DIV   = 2;
  localparam int FRAME = 100;
  localparam int SLOT  = 40;
  localparam int MINW  = 10;
  localparam int CEN   = 20;
  localparam int MAXW  = 30;
  localparam int SLEW  = 3;
  localparam int SLOTC  = SLOT * DIV;
  localparam int FRAMEC = FRAME * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  channel_en = 2'b11;
  logic [31:0] position = '0;
  logic        load = 1'b0;
  logic [1:0]  pwm;
  logic        frame_start;
  logic        busy;

  rcservo_sequencer #(
    .CHANNELS(2), .TICK_DIV(DIV), .FRAME_US(FRAME), .SLOT_US(SLOT),
    .MIN_US(MINW), .CENTER_US(CEN), .MAX_US(MAXW), .SLEW_US(SLEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .channel_en(channel_en),
    .position(position), .load(load), .pwm(pwm), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = 0;  // 0 idle, 1 start, 2 run
  int m_off = 0;   // clocks into the RUN portion of the frame
  int m_slot = 0;
  int m_shadow [2] = '{CEN, CEN};
  int m_active [2] = '{CEN, CEN};
  bit m_stop = 0;
  bit m_lat = 0;
  bit new_slot;
  int m_pwm = 0;
  int m_fs = 0;
  int m_busy = 0;

  function automatic int clamp_target(input logic [15:0] p);
    int v;
    v = CEN + int'($signed(p));
    if (v < MINW) v = MINW;
    if (v > MAXW) v = MAXW;
    return v;
  endfunction

  function automatic int next_width(input int a, input int s);
`ifdef RCSERVO_SLEW_EN
    int d;
    d = s - a;
    if (d > SLEW) d = SLEW;
    if (d < -SLEW) d = -SLEW;
    return a + d;
`else
    return s;
`endif
  endfunction

  initial begin
    logic [31:0] p;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_off = 0; m_stop = 0; m_lat = 0;
        for (int k = 0; k < 2; k++) begin m_shadow[k] = CEN; m_active[k] = CEN; end
      end else begin
        new_slot = 0;
        case (m_mode)
          0: if (enable) m_mode = 1;
          1: begin
            for (int k = 0; k < 2; k++) m_active[k] = next_width(m_active[k], m_shadow[k]);
            m_mode = 2; m_off = 0; m_stop = !enable; new_slot = 1;
          end
          default: begin
            if (!enable) m_stop = 1;
            if (m_off == FRAMEC - 1) m_mode = m_stop ? 0 : 1;
            else if (m_stop && ((m_off + 1) % SLOTC) == 0) m_mode = 0;
            else begin m_off++; new_slot = ((m_off % SLOTC) == 0); end
          end
        endcase
        if (new_slot) begin
          m_slot = m_off / SLOTC;
          m_lat = (m_slot < 2) ? (channel_en[m_slot] && !m_stop) : 1'b0;
        end
        if (load) begin
          p = position;
          for (int k = 0; k < 2; k++) m_shadow[k] = clamp_target(p[16*k +: 16]);
        end
      end
      m_pwm = 0;
      if (m_mode == 2) begin
        m_slot = m_off / SLOTC;
        for (int k = 0; k < 2; k++)
          if (m_slot == k && m_lat && (m_off % SLOTC) < m_active[k] * DIV) m_pwm |= (1 << k);
      end
      m_fs = (m_mode == 1);
      m_busy = (m_mode != 0);
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("pwm", int'(pwm), m_pwm);
      check("frame_start", int'(frame_start), m_fs);
      check("busy", int'(busy), m_busy);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 1000);
    check(tag, int'(frame_start), 1);
  endtask

  // Called in the frame_start cycle; ends in the next frame_start cycle (or after a bound).
  task automatic measure(output int hi0, output int hi1, output int r0, output int r1,
                         output int per);
    hi0 = 0; hi1 = 0; r0 = -1; r1 = -1; per = -1;
    for (int i = 1; i <= 450; i++) begin
      @(negedge clk);
      if (pwm[0]) begin hi0++; if (r0 < 0) r0 = i; end
      if (pwm[1]) begin hi1++; if (r1 < 0) r1 = i; end
      if (frame_start) begin per = i; break; end
    end
  endtask

  task automatic pulse_load(input logic [31:0] pos);
    position = pos;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  int h0, h1, r0, r1, per;
  int fsn, bfall, pick, a, b;
  int exp2_0, exp2_1, exp3_0, exp3_1;
  int exp6 [5];

  initial begin
`ifdef RCSERVO_SLEW_EN
    exp2_0 = 46; exp2_1 = 34; exp3_0 = 52; exp3_1 = 28;
    exp6[0] = 46; exp6[1] = 52; exp6[2] = 58; exp6[3] = 60; exp6[4] = 60;
`else
    exp2_0 = 60; exp2_1 = 20; exp3_0 = 60; exp3_1 = 20;
    for (int i = 0; i < 5; i++) exp6[i] = 60;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_busy", int'(busy), 0);

    // 1: basic frame timing
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("fs_early", int'(frame_start), 0);
    @(negedge clk);
    check("fs_latency", int'(frame_start), 1);
    measure(h0, h1, r0, r1, per);
    check("s1_hi0", h0, 40); check("s1_hi1", h1, 40);
    check("s1_rise0", r0, 1); check("s1_rise1", r1, 81); check("s1_period", per, 201);

    // 2: clamped load mid-frame, visible from the next frame
    repeat (20) @(negedge clk);
    pulse_load({16'hFFCE, 16'h0032});
    wait_fs("s2_fs");
    measure(h0, h1, r0, r1, per);
    check("s2_hi0", h0, exp2_0); check("s2_hi1", h1, exp2_1); check("s2_period", per, 201);

    // 3: load in the frame_start cycle applies one frame later
    pulse_load({16'hFFFB, 16'h0005});
    measure(h0, h1, r0, r1, per);
    check("s3_cur_hi0", h0, exp3_0); check("s3_cur_hi1", h1, exp3_1);
    measure(h0, h1, r0, r1, per);
    check("s3_next_hi0", h0, 50); check("s3_next_hi1", h1, 30);

    // 4: enable dropped 10 clocks into pulse 0
    h0 = 0; h1 = 0; fsn = 0; bfall = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (pwm[0]) h0++;
      if (pwm[1]) h1++;
      if (frame_start) fsn++;
      if (!busy && bfall < 0) bfall = i;
      if (i == 10) enable = 1'b0;
    end
    check("s4_hi0", h0, 50); check("s4_hi1", h1, 0);
    check("s4_fs", fsn, 0); check("s4_busy_fall", bfall, 81);

    // 5: channel 0 disabled, channel 1 timing unchanged
    channel_en = 2'b10;
    enable = 1'b1;
    wait_fs("s5_fs");
    measure(h0, h1, r0, r1, per);
    check("s5_hi0", h0, 0); check("s5_hi1", h1, 30);
    check("s5_rise1", r1, 81); check("s5_period", per, 201);
    channel_en = 2'b11;

    // Random loads, channel enables and enable drops against the model
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(1, 250)) @(negedge clk);
      pick = $urandom_range(0, 5);
      if (pick <= 1) begin
        if ($urandom_range(0, 1) == 1) begin
          pulse_load($urandom);
        end else begin
          a = $urandom_range(0, 40) - 20;
          b = $urandom_range(0, 40) - 20;
          pulse_load({16'(b), 16'(a)});
        end
      end else if (pick == 2) begin
        channel_en = 2'($urandom_range(0, 3));
      end else if (pick == 3) begin
        enable = 1'b0;
      end else begin
        enable = 1'b1;
      end
    end

    // 6: slew from centre toward +10
    enable = 1'b0;
    channel_en = 2'b11;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_load({16'd10, 16'd10});
    enable = 1'b1;
    wait_fs("s6_fs");
    for (int f = 0; f < 5; f++) begin
      measure(h0, h1, r0, r1, per);
      check($sformatf("s6_hi0_f%0d", f), h0, exp6[f]);
      check($sformatf("s6_hi1_f%0d", f), h1, exp6[f]);
    end

    enable = 1'b0;
    repeat (450) @(negedge clk);
    check("end_idle", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
